// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator. S1 decodes and sign-extends the immediate to
// XLEN; S2 forms the PC-relative target. Valid/ready handshake with flush.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Inst,
    input  logic [2:0]       ImmSrc,
    input  logic [XLEN-1:0]  InPC,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ImmExt,
    output logic [XLEN-1:0]  Target,
    output logic [TAG_W-1:0] OutTag,
    output logic             Illegal
);

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_Z = 3'b011,
        IMM_B = 3'b101,
        IMM_J = 3'b110
    } imm_sel_e;

    logic [31:0]      imm32;
    logic             illegal_d;
    logic [XLEN-1:0]  imm_d;

    logic             s1_valid;
    logic             s1_illegal;
    logic [XLEN-1:0]  s1_imm;
    logic [XLEN-1:0]  s1_pc;
    logic [TAG_W-1:0] s1_tag;

    logic             s1_load;
    logic             s2_load;

    // The opcode field carries no immediate bits.
    logic             unused_opcode;
    assign unused_opcode = ^Inst[6:0];

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        imm32     = '0;
        illegal_d = 1'b0;
        case (ImmSrc)
            IMM_I:   imm32 = {{20{Inst[31]}}, Inst[31:20]};
            IMM_S:   imm32 = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
            IMM_B:   imm32 = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
            IMM_U:   imm32 = {Inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, Inst[19:15]};
            default: illegal_d = 1'b1;
        endcase
    end

    // Every 32-bit form already carries its correct top bit, so one signed
    // widening covers the sign- and zero-extended cases alike.
    assign imm_d = XLEN'($signed(imm32));

    assign s2_load = !OutValid || OutReady;
    assign s1_load = !s1_valid || s2_load;
    assign InReady = s1_load;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_imm     <= '0;
            s1_pc      <= '0;
            s1_tag     <= '0;
        end else begin
            if (Flush) begin
                s1_valid <= 1'b0;
            end else if (s1_load) begin
                s1_valid <= InValid;
            end
            if (s1_load) begin
                s1_illegal <= illegal_d;
                s1_imm     <= imm_d;
                s1_pc      <= InPC;
                s1_tag     <= InTag;
            end
        end
    end

    // NOTE: the data registers are reset as well as the valid bit because the
    // outputs must read zero after reset; flush only clears the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            OutValid <= 1'b0;
            Illegal  <= 1'b0;
            ImmExt   <= '0;
            Target   <= '0;
            OutTag   <= '0;
        end else begin
            if (Flush) begin
                OutValid <= 1'b0;
            end else if (s2_load) begin
                OutValid <= s1_valid;
            end
            if (s2_load) begin
                Illegal <= s1_illegal;
                ImmExt  <= s1_imm;
                Target  <= s1_pc + s1_imm;
                OutTag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table through a scoreboard,
// plus stall, flush, reset and 64-bit sequences.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [31:0] pc;
        logic [4:0]  tag;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, Flush, InValid, InReady, OutValid, OutReady, Illegal;
    logic [31:0] Inst, InPC, ImmExt, Target;
    logic [2:0]  ImmSrc;
    logic [4:0]  InTag, OutTag;

    logic        reset64_unused_tie;
    logic        v64, rdy64_out, ov64, ill64;
    logic [31:0] inst64;
    logic [2:0]  src64;
    logic [63:0] pc64, imm64, tgt64;
    logic [4:0]  tag64, otag64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .Inst(Inst), .ImmSrc(ImmSrc), .InPC(InPC), .InTag(InTag),
        .OutValid(OutValid), .OutReady(OutReady), .ImmExt(ImmExt), .Target(Target),
        .OutTag(OutTag), .Illegal(Illegal)
    );

    assign reset64_unused_tie = 1'b0;

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .Flush(reset64_unused_tie), .InValid(v64), .InReady(rdy64_out),
        .Inst(inst64), .ImmSrc(src64), .InPC(pc64), .InTag(tag64),
        .OutValid(ov64), .OutReady(1'b1), .ImmExt(imm64), .Target(tgt64),
        .OutTag(otag64), .Illegal(ill64)
    );

    int   checks = 0;
    int   passes = 0;
    int   stall_cycles = 0;
    vec_t sb[$];
    vec_t cur_exp;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event not seen within its bound", name);
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] pc,
                                input logic [4:0] tag, input logic [31:0] imm, input logic [31:0] tgt,
                                input logic ill);
        vec_t v;
        v.inst = inst; v.src = src; v.pc = pc; v.tag = tag;
        v.imm = imm; v.tgt = tgt; v.ill = ill;
        return v;
    endfunction

    // I-type beat whose immediate equals its tag, at PC 0x100.
    function automatic vec_t tag_vec(input logic [4:0] t);
        return mk({7'b0, t, 20'h00093}, 3'b000, 32'h100, t, {27'b0, t}, 32'h100 + {27'b0, t}, 1'b0);
    endfunction

    // Scoreboard monitor plus output-stability check while stalled.
    logic        hold_prev = 1'b0;
    logic [31:0] hold_imm, hold_tgt;
    logic [4:0]  hold_tag;
    logic        hold_ill;

    always @(negedge clk) begin
        vec_t e;
        if (hold_prev) begin
            check("hold_valid", OutValid, 1);
            check("hold_imm", ImmExt, hold_imm);
            check("hold_target", Target, hold_tgt);
            check("hold_tag", OutTag, hold_tag);
            check("hold_illegal", Illegal, hold_ill);
        end
        hold_prev = OutValid && !OutReady && !Flush && !reset;
        hold_imm  = ImmExt;
        hold_tgt  = Target;
        hold_tag  = OutTag;
        hold_ill  = Illegal;
        if (reset) begin
            sb.delete();
        end else begin
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got tag 0x%0h, expected no beat", OutTag);
                end else begin
                    e = sb.pop_front();
                    check("out_imm", ImmExt, e.imm);
                    check("out_target", Target, e.tgt);
                    check("out_tag", OutTag, e.tag);
                    check("out_illegal", Illegal, e.ill);
                end
            end
            if (Flush) sb.delete();
            else if (InValid && InReady) sb.push_back(cur_exp);
        end
    end

    task automatic present(input vec_t v);
        Inst = v.inst; ImmSrc = v.src; InPC = v.pc; InTag = v.tag;
        InValid = 1'b1;
        cur_exp = v;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive(input vec_t v);
        bit acc;
        int n = 0;
        present(v);
        do begin
            @(negedge clk);
            acc = InReady;
            @(posedge clk);
            #1;
            if (!acc) begin
                stall_cycles++;
                n++;
            end
        end while (!acc && n < 50);
        if (!acc) fail_now("accept_timeout");
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        Inst = '0; ImmSrc = '0; InPC = '0; InTag = '0;
        v64 = 1'b0; inst64 = '0; src64 = '0; pc64 = '0; tag64 = '0;

        vecs[0] = mk(32'hFFF00093, 3'b000, 32'h0000_0100, 5'd1,  32'hFFFF_FFFF, 32'h0000_00FF, 1'b0);
        vecs[1] = mk(32'hFE000EE3, 3'b101, 32'h0000_1000, 5'd2,  32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0);
        vecs[2] = mk(32'h008000EF, 3'b110, 32'h0000_0200, 5'd3,  32'h0000_0008, 32'h0000_0208, 1'b0);
        vecs[3] = mk(32'hFFFFFFFF, 3'b111, 32'h0000_0040, 5'd4,  32'h0000_0000, 32'h0000_0040, 1'b1);
        vecs[4] = mk(32'h12345678, 3'b100, 32'h0000_0080, 5'd5,  32'h0000_0000, 32'h0000_0080, 1'b1);
        vecs[5] = mk(32'h000F8073, 3'b011, 32'h0000_0300, 5'd6,  32'h0000_001F, 32'h0000_031F, 1'b0);
        vecs[6] = mk(32'hFE512C23, 3'b001, 32'h0000_0010, 5'd7,  32'hFFFF_FFF8, 32'h0000_0008, 1'b0);
        vecs[7] = mk(32'h800000B7, 3'b010, 32'h0000_0004, 5'd8,  32'h8000_0000, 32'h8000_0004, 1'b0);
        vecs[8] = mk(32'h7FF00093, 3'b000, 32'hFFFF_FFF0, 5'd9,  32'h0000_07FF, 32'h0000_07EF, 1'b0);
        vecs[9] = mk(32'hFFFFFFFF, 3'b011, 32'h0000_0000, 5'd10, 32'h0000_001F, 32'h0000_001F, 1'b0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outvalid", OutValid, 0);
        check("rst_inready", InReady, 1);
        check("rst_imm", ImmExt, 0);
        check("rst_target", Target, 0);
        check("rst_tag", OutTag, 0);
        check("rst_illegal", Illegal, 0);
        check("rst64_outvalid", ov64, 0);
        @(posedge clk);
        #1;

        // Two-cycle latency of a single beat.
        present(vecs[0]);
        @(negedge clk);
        check("lat_inready", InReady, 1);
        @(posedge clk);
        #1 InValid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_outvalid", OutValid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_outvalid", OutValid, 1);
        @(posedge clk);
        #1;
        drain();

        // Vector table, back to back at full throughput.
        stall_cycles = 0;
        for (int i = 0; i < 10; i++) drive(vecs[i]);
        drain();
        check("throughput_no_stall", stall_cycles, 0);

        // Backpressure: two beats fill the pipe, the third waits.
        OutReady = 1'b0;
        drive(tag_vec(5'd1));
        drive(tag_vec(5'd2));
        present(tag_vec(5'd3));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_inready", InReady, 0);
            check("stall_head_tag", OutTag, 1);
            @(posedge clk);
            #1;
        end
        OutReady = 1'b1;
        drive(tag_vec(5'd3));
        drive(tag_vec(5'd4));
        drain();

        // Flush with two beats in flight and a new beat offered.
        OutReady = 1'b0;
        drive(tag_vec(5'd11));
        drive(tag_vec(5'd12));
        present(tag_vec(5'd13));
        Flush = 1'b1;
        @(posedge clk);
        #1 Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        @(negedge clk);
        check("flush_outvalid", OutValid, 0);
        check("flush_inready", InReady, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_s1_empty", OutValid, 0);
        @(posedge clk);
        #1;
        drive(vecs[1]);
        drain();

        // Reset in the middle of a stream.
        OutReady = 1'b0;
        drive(vecs[2]);
        drive(vecs[3]);
        present(vecs[6]);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; InValid = 1'b0;
        @(negedge clk);
        check("mrst_outvalid", OutValid, 0);
        check("mrst_imm", ImmExt, 0);
        check("mrst_target", Target, 0);
        check("mrst_tag", OutTag, 0);
        check("mrst_illegal", Illegal, 0);
        check("mrst_inready", InReady, 1);
        @(posedge clk);
        #1 OutReady = 1'b1;
        @(negedge clk);
        check("mrst_no_beat", OutValid, 0);
        @(posedge clk);
        #1;
        drive(vecs[7]);
        drain();

        // 64-bit instance: three back-to-back beats.
        v64 = 1'b1; inst64 = 32'h800000B7; src64 = 3'b010; pc64 = 64'h10; tag64 = 5'd1;
        @(posedge clk);
        #1 inst64 = 32'h123450B7; tag64 = 5'd2;
        @(posedge clk);
        #1 inst64 = 32'hFE000EE3; src64 = 3'b101; pc64 = 64'h1000; tag64 = 5'd3;
        @(negedge clk);
        check("x64_u_neg_valid", ov64, 1);
        check("x64_u_neg_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        check("x64_u_neg_target", tgt64, 64'hFFFF_FFFF_8000_0010);
        @(posedge clk);
        #1 v64 = 1'b0;
        @(negedge clk);
        check("x64_u_pos_imm", imm64, 64'h0000_0000_1234_5000);
        check("x64_u_pos_target", tgt64, 64'h0000_0000_1234_5010);
        check("x64_u_pos_tag", otag64, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("x64_b_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("x64_b_target", tgt64, 64'h0000_0000_0000_0FFC);
        check("x64_b_illegal", ill64, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("x64_idle_valid", ov64, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
